// File: rtl/tlb_lookup_arbiter.sv
// Arbitrates one shared combinational TLB lookup unit between the fetch and
// memory translation requesters, one transaction in flight at a time.

package tlb_lookup_pkg;
    typedef logic [31:0] virt_t;
    typedef logic [31:0] phy_t;
    typedef logic [1:0]  mat_t;
    typedef logic [5:0]  esubcode_ecode_t;

    localparam esubcode_ecode_t ECODE_PIF = 6'h03;
    localparam esubcode_ecode_t ECODE_PME = 6'h04;

    typedef enum logic [1:0] {
        LOOKUP_FETCH = 2'd0,
        LOOKUP_LOAD  = 2'd1,
        LOOKUP_STORE = 2'd2
    } tlb_lookup_type_t;
endpackage

module tlb_lookup_arbiter
    import tlb_lookup_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             if_req_valid,
    output logic             if_req_ready,
    input  virt_t            if_va,
    input  logic             if_flush,
    output logic             if_rsp_valid,
    input  logic             if_rsp_ready,
    output phy_t             if_rsp_pa,
    output mat_t             if_rsp_mat,
    output esubcode_ecode_t  if_rsp_ecode,
    output logic             if_rsp_is_exc,

    input  logic             mem_req_valid,
    output logic             mem_req_ready,
    input  virt_t            mem_va,
    input  tlb_lookup_type_t mem_type,
    output logic             mem_rsp_valid,
    input  logic             mem_rsp_ready,
    output phy_t             mem_rsp_pa,
    output mat_t             mem_rsp_mat,
    output esubcode_ecode_t  mem_rsp_ecode,
    output logic             mem_rsp_is_exc,

    output virt_t            lk_va,
    output tlb_lookup_type_t lk_type,
    input  phy_t             lk_pa,
    input  mat_t             lk_mat,
    input  esubcode_ecode_t  lk_ecode,
    input  logic             lk_is_exc,

    input  logic             tlb_busy,
    output logic             arb_idle
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t           state;
    logic [3:0]       starve_cnt;
    virt_t            va_q;
    tlb_lookup_type_t type_q;
    logic             owner_mem;

    logic fetch_ok;
    logic can_grant;
    logic grant_fetch;
    logic grant_mem;
    logic accept_fetch;
    logic accept_mem;

    // NOTE: ready is a combinational decode of registered state, so it is
    // also gated by rst_n to stay low while reset is held.
    assign fetch_ok     = if_req_valid & ~if_flush;
    assign can_grant    = rst_n & ~tlb_busy & (state == IDLE);
    assign grant_fetch  = fetch_ok & (~mem_req_valid | (starve_cnt == LIMIT));
    assign grant_mem    = mem_req_valid & ~grant_fetch;
    assign if_req_ready = can_grant & grant_fetch;
    assign mem_req_ready = can_grant & grant_mem;
    assign accept_fetch = if_req_valid & if_req_ready;
    assign accept_mem   = mem_req_valid & mem_req_ready;

    assign lk_va    = va_q;
    assign lk_type  = type_q;
    assign arb_idle = (state == IDLE);

    // NOTE: all state, including response payload, uses non-blocking
    // assignments under a synchronous reset so every flop clears on the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            starve_cnt     <= '0;
            va_q           <= '0;
            type_q         <= LOOKUP_FETCH;
            owner_mem      <= 1'b0;
            if_rsp_valid   <= 1'b0;
            if_rsp_pa      <= '0;
            if_rsp_mat     <= '0;
            if_rsp_ecode   <= '0;
            if_rsp_is_exc  <= 1'b0;
            mem_rsp_valid  <= 1'b0;
            mem_rsp_pa     <= '0;
            mem_rsp_mat    <= '0;
            mem_rsp_ecode  <= '0;
            mem_rsp_is_exc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_fetch) begin
                        va_q       <= if_va;
                        type_q     <= LOOKUP_FETCH;
                        owner_mem  <= 1'b0;
                        starve_cnt <= '0;
                        state      <= LOOKUP;
                    end else if (accept_mem) begin
                        va_q      <= mem_va;
                        type_q    <= mem_type;
                        owner_mem <= 1'b1;
                        // Only a win over a waiting, grantable fetch counts as starvation.
                        if (fetch_ok && (starve_cnt != LIMIT))
                            starve_cnt <= starve_cnt + 4'd1;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (owner_mem) begin
                        mem_rsp_pa     <= lk_pa;
                        mem_rsp_mat    <= lk_mat;
                        mem_rsp_ecode  <= lk_ecode;
                        mem_rsp_is_exc <= lk_is_exc;
                        mem_rsp_valid  <= 1'b1;
                        state          <= RESP;
                    end else if (if_flush) begin
                        state <= IDLE;
                    end else begin
                        if_rsp_pa     <= lk_pa;
                        if_rsp_mat    <= lk_mat;
                        if_rsp_ecode  <= lk_ecode;
                        if_rsp_is_exc <= lk_is_exc;
                        if_rsp_valid  <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (owner_mem) begin
                        if (mem_rsp_ready) begin
                            mem_rsp_valid <= 1'b0;
                            state         <= IDLE;
                        end
                    end else if (if_flush || if_rsp_ready) begin
                        if_rsp_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Self-checking bench for tlb_lookup_arbiter: reset, table-driven single
// transactions, directed corner sequences and a randomized model comparison.

module tb_tlb_lookup_arbiter;
    import tlb_lookup_pkg::*;

    localparam int LIMIT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             if_req_valid, if_req_ready, if_flush;
    virt_t            if_va;
    logic             if_rsp_valid, if_rsp_ready, if_rsp_is_exc;
    phy_t             if_rsp_pa;
    mat_t             if_rsp_mat;
    esubcode_ecode_t  if_rsp_ecode;
    logic             mem_req_valid, mem_req_ready;
    virt_t            mem_va;
    tlb_lookup_type_t mem_type;
    logic             mem_rsp_valid, mem_rsp_ready, mem_rsp_is_exc;
    phy_t             mem_rsp_pa;
    mat_t             mem_rsp_mat;
    esubcode_ecode_t  mem_rsp_ecode;
    virt_t            lk_va;
    tlb_lookup_type_t lk_type;
    phy_t             lk_pa;
    mat_t             lk_mat;
    esubcode_ecode_t  lk_ecode;
    logic             lk_is_exc;
    logic             tlb_busy, arb_idle;

    // Lookup-unit stand-in: combinational in lk_va/lk_type, shaped by knobs.
    phy_t             pa_xor;
    logic             exc_on;
    esubcode_ecode_t  ecode_knob;

    assign lk_pa     = lk_va ^ pa_xor ^ {30'd0, lk_type};
    assign lk_mat    = lk_va[5:4];
    assign lk_ecode  = exc_on ? ecode_knob : '0;
    assign lk_is_exc = exc_on;

    always #5 clk = ~clk;

    tlb_lookup_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_va(if_va),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
        .if_rsp_pa(if_rsp_pa), .if_rsp_mat(if_rsp_mat), .if_rsp_ecode(if_rsp_ecode),
        .if_rsp_is_exc(if_rsp_is_exc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_va(mem_va),
        .mem_type(mem_type), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_pa(mem_rsp_pa), .mem_rsp_mat(mem_rsp_mat), .mem_rsp_ecode(mem_rsp_ecode),
        .mem_rsp_is_exc(mem_rsp_is_exc),
        .lk_va(lk_va), .lk_type(lk_type), .lk_pa(lk_pa), .lk_mat(lk_mat),
        .lk_ecode(lk_ecode), .lk_is_exc(lk_is_exc),
        .tlb_busy(tlb_busy), .arb_idle(arb_idle)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Present one request and wait (bounded) for its accept edge; returns in the LOOKUP cycle.
    task automatic issue(input logic is_mem, input virt_t va, input tlb_lookup_type_t t);
        logic ok;
        ok = 1'b0;
        if (is_mem) begin
            mem_req_valid = 1'b1; mem_va = va; mem_type = t;
        end else begin
            if_req_valid = 1'b1; if_va = va;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((is_mem && mem_req_ready) || (!is_mem && if_req_ready)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("accept_seen", ok, 1'b1);
        tick();
        if (is_mem) mem_req_valid = 1'b0;
        else        if_req_valid  = 1'b0;
    endtask

    // Both requesters always valid; grant k is fetch when k%5==4 from a cleared counter.
    task automatic run_contention(input int n);
        if_req_valid = 1'b1; mem_req_valid = 1'b1;
        if_rsp_ready = 1'b1; mem_rsp_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            if_va  = 32'h0000_1000 + 32'(k);
            mem_va = 32'h0000_2000 + 32'(k);
            #1;
            check($sformatf("contend_mem_grant_%0d", k), mem_req_ready, (k % 5) != 4);
            check($sformatf("contend_if_grant_%0d", k), if_req_ready, (k % 5) == 4);
            tick(); tick(); tick();
        end
        if_req_valid = 1'b0; mem_req_valid = 1'b0;
    endtask

    typedef struct {
        logic             is_mem;
        virt_t            va;
        tlb_lookup_type_t t;
        logic             exc;
        esubcode_ecode_t  ec;
        phy_t             exp_pa;
        mat_t             exp_mat;
    } vec_t;

    vec_t vecs[5];

    // Random-phase reference model state.
    logic             pend, pend_mem;
    virt_t            pend_va;
    tlb_lookup_type_t pend_type;
    int               age, mem_wins;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        if_req_valid = 1'b0; if_va = '0; if_flush = 1'b0; if_rsp_ready = 1'b0;
        mem_req_valid = 1'b0; mem_va = '0; mem_type = LOOKUP_LOAD; mem_rsp_ready = 1'b0;
        tlb_busy = 1'b0; pa_xor = '0; exc_on = 1'b0; ecode_knob = '0;

        // Reset state, with both requesters asserting valid.
        if_req_valid = 1'b1; mem_req_valid = 1'b1;
        tick(); #1;
        check("rst_if_ready", if_req_ready, 1'b0);
        check("rst_mem_ready", mem_req_ready, 1'b0);
        check("rst_arb_idle", arb_idle, 1'b1);
        check("rst_if_rsp_valid", if_rsp_valid, 1'b0);
        check("rst_mem_rsp_valid", mem_rsp_valid, 1'b0);
        check("rst_lk_va", lk_va, 32'h0);
        check("rst_lk_type", lk_type, LOOKUP_FETCH);
        check("rst_mem_rsp_pa", mem_rsp_pa, 32'h0);
        if_req_valid = 1'b0; mem_req_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Single fetch with timing: accept N, LOOKUP N+1, response N+2.
        pa_xor = 32'h1C00_0000; if_rsp_ready = 1'b1; mem_rsp_ready = 1'b1;
        issue(1'b0, 32'h1C00_0000, LOOKUP_FETCH);
        check("sf_lookup_rsp_valid", if_rsp_valid, 1'b0);
        check("sf_lookup_idle", arb_idle, 1'b0);
        check("sf_lk_va", lk_va, 32'h1C00_0000);
        check("sf_lk_type", lk_type, LOOKUP_FETCH);
        tick();
        check("sf_rsp_valid", if_rsp_valid, 1'b1);
        check("sf_rsp_pa", if_rsp_pa, 32'h0);
        check("sf_rsp_exc", if_rsp_is_exc, 1'b0);
        check("sf_mem_rsp_valid", mem_rsp_valid, 1'b0);
        tick();
        check("sf_back_idle", arb_idle, 1'b1);
        check("sf_rsp_dropped", if_rsp_valid, 1'b0);

        // Table-driven single transactions; pa = va ^ type with pa_xor cleared.
        vecs[0] = '{1'b0, 32'h1C00_0040, LOOKUP_FETCH, 1'b0, 6'h00,      32'h1C00_0040, 2'd0};
        vecs[1] = '{1'b1, 32'h0000_1234, LOOKUP_LOAD,  1'b0, 6'h00,      32'h0000_1235, 2'd3};
        vecs[2] = '{1'b1, 32'h8000_1230, LOOKUP_STORE, 1'b1, ECODE_PME,  32'h8000_1232, 2'd3};
        vecs[3] = '{1'b0, 32'h0000_0010, LOOKUP_FETCH, 1'b1, ECODE_PIF,  32'h0000_0010, 2'd1};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF, LOOKUP_LOAD,  1'b0, 6'h00,      32'hFFFF_FFFE, 2'd3};
        pa_xor = '0;
        for (int v = 0; v < 5; v++) begin
            exc_on = vecs[v].exc; ecode_knob = vecs[v].ec;
            issue(vecs[v].is_mem, vecs[v].va, vecs[v].t);
            tick();
            if (vecs[v].is_mem) begin
                check($sformatf("vec%0d_valid", v), mem_rsp_valid, 1'b1);
                check($sformatf("vec%0d_other", v), if_rsp_valid, 1'b0);
                check($sformatf("vec%0d_pa", v), mem_rsp_pa, vecs[v].exp_pa);
                check($sformatf("vec%0d_mat", v), mem_rsp_mat, vecs[v].exp_mat);
                check($sformatf("vec%0d_exc", v), mem_rsp_is_exc, vecs[v].exc);
                check($sformatf("vec%0d_ecode", v), mem_rsp_ecode, vecs[v].ec);
            end else begin
                check($sformatf("vec%0d_valid", v), if_rsp_valid, 1'b1);
                check($sformatf("vec%0d_other", v), mem_rsp_valid, 1'b0);
                check($sformatf("vec%0d_pa", v), if_rsp_pa, vecs[v].exp_pa);
                check($sformatf("vec%0d_mat", v), if_rsp_mat, vecs[v].exp_mat);
                check($sformatf("vec%0d_exc", v), if_rsp_is_exc, vecs[v].exc);
                check($sformatf("vec%0d_ecode", v), if_rsp_ecode, vecs[v].ec);
            end
            tick();
        end
        exc_on = 1'b0; ecode_knob = '0;

        // Contention from a cleared starvation counter: M,M,M,M,F,M,M,M,M,F.
        do_reset();
        run_contention(10);

        // Backpressure on the mem response while fetch waits.
        mem_rsp_ready = 1'b0;
        issue(1'b1, 32'h4000_0100, LOOKUP_LOAD);
        if_req_valid = 1'b1; if_va = 32'h0000_0500;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp%0d_valid", c), mem_rsp_valid, 1'b1);
            check($sformatf("bp%0d_pa", c), mem_rsp_pa, 32'h4000_0101);
            check($sformatf("bp%0d_if_ready", c), if_req_ready, 1'b0);
            check($sformatf("bp%0d_mem_ready", c), mem_req_ready, 1'b0);
            check($sformatf("bp%0d_idle", c), arb_idle, 1'b0);
            tick();
        end
        mem_rsp_ready = 1'b1;
        tick(); #1;
        check("bp_done_idle", arb_idle, 1'b1);
        check("bp_done_valid", mem_rsp_valid, 1'b0);
        check("bp_fetch_ready", if_req_ready, 1'b1);
        if_req_valid = 1'b0;

        // Flush during LOOKUP: no response, back to IDLE, fetch not grantable.
        issue(1'b0, 32'h0000_0600, LOOKUP_FETCH);
        if_flush = 1'b1;
        tick();
        check("flk_rsp_valid", if_rsp_valid, 1'b0);
        check("flk_idle", arb_idle, 1'b1);
        if_req_valid = 1'b1; #1;
        check("flk_fetch_blocked", if_req_ready, 1'b0);
        if_req_valid = 1'b0; if_flush = 1'b0;
        tick();
        check("flk_no_late_rsp", if_rsp_valid, 1'b0);

        // Flush in RESP together with rsp_ready: valid drops, IDLE.
        if_rsp_ready = 1'b0;
        issue(1'b0, 32'h0000_0700, LOOKUP_FETCH);
        tick();
        check("frs_valid_before", if_rsp_valid, 1'b1);
        if_flush = 1'b1; if_rsp_ready = 1'b1;
        tick();
        check("frs_valid_after", if_rsp_valid, 1'b0);
        check("frs_idle", arb_idle, 1'b1);
        if_flush = 1'b0;

        // Mem transaction ignores if_flush.
        issue(1'b1, 32'h0000_0800, LOOKUP_STORE);
        if_flush = 1'b1;
        tick();
        check("fmem_valid", mem_rsp_valid, 1'b1);
        check("fmem_pa", mem_rsp_pa, 32'h0000_0802);
        if_flush = 1'b0;
        tick();

        // tlb_busy blocks grants but not a transaction already past IDLE.
        tlb_busy = 1'b1; if_req_valid = 1'b1; mem_req_valid = 1'b1; #1;
        check("busy_if_ready", if_req_ready, 1'b0);
        check("busy_mem_ready", mem_req_ready, 1'b0);
        tick();
        check("busy_idle", arb_idle, 1'b1);
        if_req_valid = 1'b0; mem_req_valid = 1'b0; tlb_busy = 1'b0;
        issue(1'b1, 32'h0000_0900, LOOKUP_LOAD);
        tlb_busy = 1'b1;
        tick();
        check("busy_lk_completes", mem_rsp_valid, 1'b1);
        tick();
        check("busy_lk_idle", arb_idle, 1'b1);
        mem_req_valid = 1'b1; #1;
        check("busy_still_blocked", mem_req_ready, 1'b0);
        mem_req_valid = 1'b0; tlb_busy = 1'b0;

        // Reset in RESP drops the response and clears starvation.
        do_reset();
        run_contention(4);
        mem_rsp_ready = 1'b0;
        issue(1'b1, 32'h0000_0A00, LOOKUP_LOAD);
        tick();
        check("rr_valid_before", mem_rsp_valid, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rr_valid_after", mem_rsp_valid, 1'b0);
        check("rr_idle", arb_idle, 1'b1);
        check("rr_pa_cleared", mem_rsp_pa, 32'h0);
        run_contention(1);

        // Randomized traffic against a transaction-level model.
        do_reset();
        pa_xor = $urandom;
        pend = 1'b0; pend_mem = 1'b0; pend_va = '0; pend_type = LOOKUP_FETCH;
        age = 0; mem_wins = 0;
        if_req_valid = 1'b0; mem_req_valid = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic exp_if_rdy, exp_mem_rdy, rsp_vis, fetch_wins;
            if (!if_req_valid && ($urandom_range(0, 1) == 1)) begin
                if_req_valid = 1'b1; if_va = $urandom;
            end
            if (!mem_req_valid && ($urandom_range(0, 1) == 1)) begin
                mem_req_valid = 1'b1; mem_va = $urandom;
                mem_type = ($urandom_range(0, 1) == 1) ? LOOKUP_STORE : LOOKUP_LOAD;
            end
            tlb_busy      = ($urandom_range(0, 3) == 0);
            if_rsp_ready  = ($urandom_range(0, 2) != 0);
            mem_rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            fetch_wins  = if_req_valid && (!mem_req_valid || mem_wins == LIMIT);
            exp_if_rdy  = !pend && !tlb_busy && fetch_wins;
            exp_mem_rdy = !pend && !tlb_busy && mem_req_valid && !fetch_wins;
            rsp_vis     = pend && (age >= 2);
            check("rnd_if_ready", if_req_ready, exp_if_rdy);
            check("rnd_mem_ready", mem_req_ready, exp_mem_rdy);
            check("rnd_idle", arb_idle, !pend);
            check("rnd_if_rsp_valid", if_rsp_valid, rsp_vis && !pend_mem);
            check("rnd_mem_rsp_valid", mem_rsp_valid, rsp_vis && pend_mem);
            if (rsp_vis) begin
                if (pend_mem) begin
                    check("rnd_mem_pa", mem_rsp_pa, pend_va ^ pa_xor ^ {30'd0, pend_type});
                    check("rnd_mem_mat", mem_rsp_mat, pend_va[5:4]);
                end else begin
                    check("rnd_if_pa", if_rsp_pa, pend_va ^ pa_xor);
                    check("rnd_if_mat", if_rsp_mat, pend_va[5:4]);
                end
            end
            if (rsp_vis && (pend_mem ? mem_rsp_ready : if_rsp_ready)) pend = 1'b0;
            else if (pend) age++;
            if (exp_if_rdy) begin
                pend = 1'b1; pend_mem = 1'b0; pend_va = if_va; pend_type = LOOKUP_FETCH;
                age = 1; mem_wins = 0;
            end else if (exp_mem_rdy) begin
                pend = 1'b1; pend_mem = 1'b1; pend_va = mem_va; pend_type = mem_type;
                age = 1;
                if (if_req_valid && mem_wins < LIMIT) mem_wins++;
            end
            tick();
            if (exp_if_rdy)  if_req_valid  = 1'b0;
            if (exp_mem_rdy) mem_req_valid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tlb_lookup_arbiter.md
# tlb_lookup_arbiter

Shares the single combinational TLB lookup unit between the instruction-fetch and memory-access translation requesters. Accepts at most one translation at a time over valid/ready handshakes, drives the latched VA and lookup type into the lookup unit, registers its result, and returns it on the owning requester's response channel. It exposes an idle indication so the TLB maintenance sequencer (tlbwr/tlbfill/invtlb) can hold off lookups while entries change.

## Interface
- STARVE_LIMIT, 4: consecutive contended mem wins before fetch is forced a grant (1..15)
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- if_req_valid / if_req_ready  in / out  1  fetch request handshake
- if_va  in  virt_t  fetch VA (lookup type fixed LOOKUP_FETCH)
- if_flush  in  1  discard any fetch request or result in flight
- if_rsp_valid / if_rsp_ready  out / in  1  fetch response handshake
- if_rsp_pa, if_rsp_mat, if_rsp_ecode, if_rsp_is_exc  out  phy_t, mat_t, esubcode_ecode_t, 1  fetch result
- mem_req_valid / mem_req_ready  in / out  1  mem request handshake
- mem_va  in  virt_t;  mem_type  in  tlb_lookup_type_t (LOOKUP_LOAD or LOOKUP_STORE)
- mem_rsp_valid / mem_rsp_ready  out / in  1  mem response handshake
- mem_rsp_pa, mem_rsp_mat, mem_rsp_ecode, mem_rsp_is_exc  out  as fetch
- lk_va, lk_type  out  virt_t, tlb_lookup_type_t  to lookup unit
- lk_pa, lk_mat, lk_ecode, lk_is_exc  in  from lookup unit (combinational in lk_va/lk_type)
- tlb_busy  in  1  maintenance sequencer owns the TLB; no new grants
- arb_idle  out  1  high in IDLE (no lookup or response outstanding)

## Operation
- FSM: IDLE, LOOKUP, RESP. One transaction outstanding in total.
- IDLE: grant computed combinationally; if_req_ready / mem_req_ready high only for the granted requester, only when tlb_busy low. Fetch is not grantable while if_flush high.
- Grant: only one valid -> it wins. Both valid -> mem wins unless starve_cnt == STARVE_LIMIT, then fetch wins.
- starve_cnt (4 bits): +1 when mem granted while fetch valid and grantable; cleared when fetch granted; saturates at STARVE_LIMIT.
- On accept (valid & ready): latch VA, type, owner; IDLE -> LOOKUP.
- LOOKUP: lk_va/lk_type driven from latches; result captured into owner's response registers at cycle end; -> RESP, owner's rsp_valid set.
- RESP: hold rsp_valid and payload stable until owner's rsp_ready; on handshake -> IDLE (next grant earliest the following cycle).
- Flush (owner = fetch): if_flush in LOOKUP -> IDLE, no response; in RESP -> clear if_rsp_valid, IDLE. Mem transactions ignore if_flush.
- tlb_busy only gates grants; a transaction past IDLE completes normally. Maintenance must wait for arb_idle.
- Non-owner rsp_valid always 0. Result fields copied unmodified (is_exc/ecode from lookup unit).

## Timing
- Reset (rst_n low at edge): state IDLE, both rsp_valid 0, rsp_pa/mat/ecode 0, rsp_is_exc 0, starve_cnt 0, latched VA 0, lk_type LOOKUP_FETCH; req_ready 0 while rst_n low. Reset mid-transaction drops it silently.
- Accept at edge N -> lookup during cycle N+1 -> rsp_valid high cycle N+2. Minimum 3 cycles per transaction (rsp_ready held high).
- arb_idle registered state decode: low from cycle after accept until cycle after response handshake/flush.
- if_flush and if_rsp_ready same cycle in RESP: flush wins (no double-count; both end in IDLE).

## Test plan
- Single fetch: if_va=0x1C00_0000, lk_pa=0x0000_0000, rsp_ready=1 -> if_rsp_valid at N+2, pa 0x0, is_exc 0; mem_rsp_valid stays 0.
- Contention: both valid every cycle, STARVE_LIMIT=4 -> grant order M,M,M,M,F,M,M,M,M,F.
- Store exception: mem_type=LOOKUP_STORE, lk_is_exc=1, lk_ecode=PME -> mem_rsp_is_exc 1, ecode PME, pa passed through.
- Backpressure: mem_rsp_ready low 5 cycles -> mem_rsp_valid/payload stable, both req_ready 0, arb_idle 0; completes on ready.
- Flush: fetch accepted, if_flush in LOOKUP -> no if_rsp_valid, IDLE next; repeat with flush in RESP -> valid drops next cycle.
- Busy/reset: tlb_busy high with both valid -> no ready; busy asserted in LOOKUP -> transaction completes; rst_n low in RESP -> rsp_valid 0, starve_cnt 0.
